mem: RTL and testbench
======================

# mem

Memory-access stage of the dual-issue back end, between the ex/mem pipeline register and `wb`. It registers the issued bundle from execute and runs the single data-cache port for the bundle's memory lane. It aligns load data and store strobes, and holds the pipeline through `pause_mem` until the access completes. Its outputs feed `wb` directly (`wb_o`, `commit_ctrl_o`, `mem_diff_o`) and give dispatch a forwarding view of the bundle currently in the stage.

## Interface
- `ISSUE_WIDTH`, 2: `pipeline_types` package constant; lanes per bundle.
- `clk`  in  1  stage clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_i[ISSUE_WIDTH]`  in  `ex_mem_t`  bundle from execute: valid, reg_write_en/addr/data, mem_op, mem_addr[31:0], store_data[31:0].
- `commit_ctrl_i[ISSUE_WIDTH]`  in  `commit_ctrl_t`  commit info, passed through.
- `ex_diff_i[ISSUE_WIDTH]`  in  `diff_t`  difftest info, passed through.
- `flush`  in  1  from ctrl.
- `pause`  in  1  from ctrl.
- `dcache_req_valid`  out  1  request.
- `dcache_req_ready`  in  1  request accepted.
- `dcache_req_we`  out  1  1 = store.
- `dcache_req_addr`  out  32  byte address.
- `dcache_req_wstrb`  out  4  byte enables.
- `dcache_req_wdata`  out  32  lane-replicated store data.
- `dcache_resp_valid`  in  1  load data valid, one-cycle pulse.
- `dcache_resp_rdata`  in  32  raw load word.
- `pause_mem`  out  1  to ctrl; stage busy.
- `mem_reg_pf[ISSUE_WIDTH]`  out  `pipeline_push_forward_t`  to dispatch.
- `wb_o[ISSUE_WIDTH]`  out  `mem_wb_t`  to wb.
- `commit_ctrl_o[ISSUE_WIDTH]`  out  `commit_ctrl_t`  to wb.
- `mem_diff_o[ISSUE_WIDTH]`  out  `diff_t`  to wb.

## Operation
- Stage register: cleared by `rst` low or by `flush`. Loads `ex_i`, `commit_ctrl_i` and `ex_diff_i` when `!pause`. Otherwise it holds.
- Memory lane: at most one lane per bundle has `mem_op != MEM_NONE`. Dispatch guarantees this. The lower index wins if the rule is violated.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - Register load with a memory op: go to REQ. Register load without one: go to IDLE.
  - REQ: `dcache_req_valid`=1. On `dcache_req_ready`, a store goes to DONE and a load goes to WAIT.
  - WAIT: on `dcache_resp_valid`, capture aligned data into `load_data` and go to DONE.
  - DONE: hold until the next register load.
  - DRAIN: a load was accepted but flushed. Ignore the next response, then go to IDLE, or to REQ if the register now holds a memory op.
- `pause_mem` = REQ | WAIT | (DRAIN & register holds a memory op).
- Flush in REQ before a handshake: drop the request and go to IDLE.
- Flush coincident with a load handshake, or flush in WAIT: go to DRAIN.
- Flush coincident with a response in WAIT: the response is consumed and the FSM goes to IDLE.
- Load alignment, offset o = addr[1:0]:
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: the whole word.
  - Misalignment is trapped in ex; this stage assumes aligned addresses.
- Store strobes: SB = 4'b0001<<o with the byte replicated ×4. SH = 4'b0011<<(2·addr[1]) with the half replicated ×2. SW = 4'b1111.
- `wb_o`:
  - The memory lane's reg_write_data is `load_data` for loads.
  - All lanes are zeroed while `pause_mem`=1, so no partial bundle reaches wb.
- `mem_reg_pf`: en/addr/data of the stage register. A load lane's en is 0 until DONE.

## Timing
- Reset: every output is 0, FSM is IDLE, `load_data` is 0.
- Non-memory bundle: visible on `wb_o` in the cycle after capture; zero added latency.
- Store: minimum 1 cycle in REQ, then DONE; `pause_mem` high ≥1 cycle.
- Load: REQ ≥1 cycle, WAIT ≥1 cycle; `pause_mem` falls in the cycle after `dcache_resp_valid`.
- Request fields are stable while `dcache_req_valid`=1 and `dcache_req_ready`=0.
- `pause` high in DONE holds the register and holds DONE. No second request is issued.

## Structure
- `pipeline_types` gains:
  - `mem_op_t` enum: MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
  - the `mem_op`, `mem_addr` and `store_data` fields in `ex_mem_t`.
  - `mem_state_t`.
- One combinational sub-module, `mem_load_align`: takes mem_op, offset and raw word, and returns the extended result.

## Test plan
- ALU-only bundle, x5 = 0x1234 on lane 0 → `wb_o[0]` has en=1, addr=5, data=0x1234 one cycle later; `pause_mem` stays 0.
- LB at 0x1003, rdata 0x80FF_FF00 → `wb_o` data 0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- SH at 0x2002, data 0xABCD → wstrb 4'b1100, wdata 0xABCD_ABCD, we=1; `pause_mem` high exactly 1 cycle with ready already high.
- LW with ready delayed 3 cycles and response 2 cycles later → address stable throughout; `pause_mem` high 5 cycles; data forwarded only at DONE.
- `flush` in WAIT, new LW captured next → stale response ignored (DRAIN), new request issued after it; the new load returns the second response.
- `rst` low mid-REQ → `dcache_req_valid` drops asynchronously; all outputs are 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage of the dual-issue back end.
package mem_pkg;

    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned LANE_W      = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, DONE, DRAIN
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic [31:0] reg_write_data;
        mem_op_t     mem_op;
        logic [31:0] mem_addr;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } commit_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } diff_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } pipeline_push_forward_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic [31:0] reg_write_data;
    } mem_wb_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts and extends the addressed byte/half/word from a raw load word.
import mem_pkg::*;

module mem_load_align (
    input  mem_op_t     mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/half, then extend according to the op
    always_comb begin
        unique case (offset)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (mem_op)
            LB:      data = {{24{sel_byte[7]}}, sel_byte};
            LBU:     data = {24'h0, sel_byte};
            LH:      data = {{16{sel_half[15]}}, sel_half};
            LHU:     data = {16'h0, sel_half};
            LW:      data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem.sv
// Memory-access stage: stage register, single data-cache port FSM, store
// strobe generation, load alignment and forwarding view for dispatch.
import mem_pkg::*;

module mem (
    input  logic                   clk,
    input  logic                   rst,
    input  ex_mem_t                ex_i          [ISSUE_WIDTH],
    input  commit_ctrl_t           commit_ctrl_i [ISSUE_WIDTH],
    input  diff_t                  ex_diff_i     [ISSUE_WIDTH],
    input  logic                   flush,
    input  logic                   pause,
    output logic                   dcache_req_valid,
    input  logic                   dcache_req_ready,
    output logic                   dcache_req_we,
    output logic [31:0]            dcache_req_addr,
    output logic [3:0]             dcache_req_wstrb,
    output logic [31:0]            dcache_req_wdata,
    input  logic                   dcache_resp_valid,
    input  logic [31:0]            dcache_resp_rdata,
    output logic                   pause_mem,
    output pipeline_push_forward_t mem_reg_pf    [ISSUE_WIDTH],
    output mem_wb_t                wb_o          [ISSUE_WIDTH],
    output commit_ctrl_t           commit_ctrl_o [ISSUE_WIDTH],
    output diff_t                  mem_diff_o    [ISSUE_WIDTH]
);

    ex_mem_t      ex_q   [ISSUE_WIDTH];
    commit_ctrl_t cc_q   [ISSUE_WIDTH];
    diff_t        diff_q [ISSUE_WIDTH];
    mem_state_t   state;
    logic [31:0]  load_data;

    logic              mem_hit;
    logic [LANE_W-1:0] mem_lane;
    logic              ex_has_mem;
    mem_op_t           op;
    logic [31:0]       addr;
    logic [31:0]       sdata;
    logic [31:0]       aligned;

    // Locate the memory lane in the register (lowest index wins) and check the incoming bundle
    always_comb begin
        mem_hit    = 1'b0;
        mem_lane   = '0;
        ex_has_mem = 1'b0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (!mem_hit && ex_q[i].mem_op != MEM_NONE) begin
                mem_hit  = 1'b1;
                mem_lane = LANE_W'(i);
            end
            if (ex_i[i].mem_op != MEM_NONE)
                ex_has_mem = 1'b1;
        end
        op    = mem_hit ? ex_q[mem_lane].mem_op : MEM_NONE;
        addr  = ex_q[mem_lane].mem_addr;
        sdata = ex_q[mem_lane].store_data;
    end

    mem_load_align u_align (
        .mem_op (op),
        .offset (addr[1:0]),
        .rdata  (dcache_resp_rdata),
        .data   (aligned)
    );

    // Stage register: cleared by reset or flush, loaded when not paused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                ex_q[i]   <= '0;
                cc_q[i]   <= '0;
                diff_q[i] <= '0;
            end
        end else if (!pause) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                ex_q[i]   <= ex_i[i];
                cc_q[i]   <= commit_ctrl_i[i];
                diff_q[i] <= ex_diff_i[i];
            end
        end
    end

    // Cache-port FSM; DRAIN swallows the response of a load that was accepted and then flushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            load_data <= '0;
        end else if (flush) begin
            unique case (state)
                REQ:     state <= (dcache_req_ready && is_load(op)) ? DRAIN : IDLE;
                WAIT:    state <= dcache_resp_valid ? IDLE : DRAIN;
                DRAIN:   state <= dcache_resp_valid ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (!pause)
                        state <= ex_has_mem ? REQ : IDLE;
                end
                REQ: begin
                    if (dcache_req_ready)
                        state <= is_store(op) ? DONE : WAIT;
                end
                WAIT: begin
                    if (dcache_resp_valid) begin
                        load_data <= aligned;
                        state     <= DONE;
                    end
                end
                DRAIN: begin
                    // The register may be reloaded in the same cycle the stale response lands
                    if (dcache_resp_valid)
                        state <= ((!pause) ? ex_has_mem : mem_hit) ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pause_mem = (state == REQ) || (state == WAIT) || ((state == DRAIN) && mem_hit);

    // Request fields come straight from the held register, so they stay stable until accepted
    always_comb begin
        dcache_req_valid = (state == REQ);
        dcache_req_we    = 1'b0;
        dcache_req_addr  = '0;
        dcache_req_wstrb = '0;
        dcache_req_wdata = '0;
        if (dcache_req_valid) begin
            dcache_req_we   = is_store(op);
            dcache_req_addr = addr;
            case (op)
                SB: begin
                    dcache_req_wstrb = 4'b0001 << addr[1:0];
                    dcache_req_wdata = {4{sdata[7:0]}};
                end
                SH: begin
                    dcache_req_wstrb = 4'b0011 << {addr[1], 1'b0};
                    dcache_req_wdata = {2{sdata[15:0]}};
                end
                SW: begin
                    dcache_req_wstrb = 4'b1111;
                    dcache_req_wdata = sdata;
                end
                default: ;
            endcase
        end
    end

    // Writeback and forwarding views; the whole bundle is hidden while the stage is busy
    always_comb begin
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            logic ld_lane;
            ld_lane = mem_hit && (LANE_W'(i) == mem_lane) && is_load(op);

            wb_o[i].valid          = ex_q[i].valid;
            wb_o[i].reg_write_en   = ex_q[i].reg_write_en;
            wb_o[i].reg_write_addr = ex_q[i].reg_write_addr;
            wb_o[i].reg_write_data = ld_lane ? load_data : ex_q[i].reg_write_data;

            mem_reg_pf[i].en   = ex_q[i].reg_write_en && !(ld_lane && state != DONE);
            mem_reg_pf[i].addr = ex_q[i].reg_write_addr;
            mem_reg_pf[i].data = wb_o[i].reg_write_data;

            if (pause_mem)
                wb_o[i] = '0;
        end
    end

    assign commit_ctrl_o = cc_q;
    assign mem_diff_o    = diff_q;

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for the memory-access stage.
import mem_pkg::*;

module tb_mem;

    logic                   clk;
    logic                   rst;
    ex_mem_t                ex_i          [ISSUE_WIDTH];
    commit_ctrl_t           commit_ctrl_i [ISSUE_WIDTH];
    diff_t                  ex_diff_i     [ISSUE_WIDTH];
    logic                   flush;
    logic                   pause;
    logic                   tb_pause;
    logic                   dcache_req_valid;
    logic                   dcache_req_ready;
    logic                   dcache_req_we;
    logic [31:0]            dcache_req_addr;
    logic [3:0]             dcache_req_wstrb;
    logic [31:0]            dcache_req_wdata;
    logic                   dcache_resp_valid;
    logic [31:0]            dcache_resp_rdata;
    logic                   pause_mem;
    pipeline_push_forward_t mem_reg_pf    [ISSUE_WIDTH];
    mem_wb_t                wb_o          [ISSUE_WIDTH];
    commit_ctrl_t           commit_ctrl_o [ISSUE_WIDTH];
    diff_t                  mem_diff_o    [ISSUE_WIDTH];

    int total = 0;
    int bad   = 0;

    // ctrl stalls the front of the pipe whenever this stage is busy
    assign pause = pause_mem | tb_pause;

    mem dut (
        .clk               (clk),
        .rst               (rst),
        .ex_i              (ex_i),
        .commit_ctrl_i     (commit_ctrl_i),
        .ex_diff_i         (ex_diff_i),
        .flush             (flush),
        .pause             (pause),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_ready  (dcache_req_ready),
        .dcache_req_we     (dcache_req_we),
        .dcache_req_addr   (dcache_req_addr),
        .dcache_req_wstrb  (dcache_req_wstrb),
        .dcache_req_wdata  (dcache_req_wdata),
        .dcache_resp_valid (dcache_resp_valid),
        .dcache_resp_rdata (dcache_resp_rdata),
        .pause_mem         (pause_mem),
        .mem_reg_pf        (mem_reg_pf),
        .wb_o              (wb_o),
        .commit_ctrl_o     (commit_ctrl_o),
        .mem_diff_o        (mem_diff_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_t alu(input logic [4:0] rd, input logic [31:0] d);
        ex_mem_t e;
        e = '0;
        e.valid          = 1'b1;
        e.reg_write_en   = 1'b1;
        e.reg_write_addr = rd;
        e.reg_write_data = d;
        return e;
    endfunction

    function automatic ex_mem_t mop(input mem_op_t op, input logic [4:0] rd,
                                    input logic [31:0] a, input logic [31:0] sd);
        ex_mem_t e;
        e = '0;
        e.valid          = 1'b1;
        e.reg_write_en   = is_load(op);
        e.reg_write_addr = rd;
        e.mem_op         = op;
        e.mem_addr       = a;
        e.store_data     = sd;
        return e;
    endfunction

    task automatic bubble();
        for (int i = 0; i < ISSUE_WIDTH; i++) ex_i[i] = '0;
    endtask

    int pcnt;

    initial begin
        rst               = 1'b0;
        flush             = 1'b0;
        tb_pause          = 1'b0;
        dcache_req_ready  = 1'b0;
        dcache_resp_valid = 1'b0;
        dcache_resp_rdata = '0;
        bubble();
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            commit_ctrl_i[i] = '0;
            ex_diff_i[i]     = '0;
        end

        // Reset state
        step();
        step();
        chk("rst_req_valid", 32'(dcache_req_valid), 32'd0);
        chk("rst_pause_mem", 32'(pause_mem), 32'd0);
        chk("rst_wb0_en",    32'(wb_o[0].reg_write_en), 32'd0);
        chk("rst_wb0_data",  wb_o[0].reg_write_data, 32'd0);
        rst = 1'b1;
        step();

        // ALU-only bundle with commit passthrough
        ex_i[0] = alu(5'd5, 32'h1234);
        commit_ctrl_i[0] = '{valid: 1'b1, pc: 32'h8000_0010};
        step();
        bubble();
        commit_ctrl_i[0] = '0;
        chk("alu_wb_en",    32'(wb_o[0].reg_write_en), 32'd1);
        chk("alu_wb_addr",  32'(wb_o[0].reg_write_addr), 32'd5);
        chk("alu_wb_data",  wb_o[0].reg_write_data, 32'h1234);
        chk("alu_pause",    32'(pause_mem), 32'd0);
        chk("alu_pf_en",    32'(mem_reg_pf[0].en), 32'd1);
        chk("alu_cc_pc",    commit_ctrl_o[0].pc, 32'h8000_0010);
        step();

        // LB at 0x1003 on lane 1, ALU x3 on lane 0
        dcache_req_ready = 1'b1;
        ex_i[0] = alu(5'd3, 32'h55);
        ex_i[1] = mop(LB, 5'd7, 32'h1003, '0);
        step();
        bubble();
        chk("lb_req_valid", 32'(dcache_req_valid), 32'd1);
        chk("lb_req_addr",  dcache_req_addr, 32'h1003);
        chk("lb_req_we",    32'(dcache_req_we), 32'd0);
        chk("lb_pause",     32'(pause_mem), 32'd1);
        chk("lb_wb0_zero",  wb_o[0].reg_write_data, 32'd0);
        step();
        chk("lb_wait_valid", 32'(dcache_req_valid), 32'd0);
        chk("lb_wait_pf_en", 32'(mem_reg_pf[1].en), 32'd0);
        dcache_resp_valid = 1'b1;
        dcache_resp_rdata = 32'h80FF_FF00;
        step();
        dcache_resp_valid = 1'b0;
        chk("lb_done_pause", 32'(pause_mem), 32'd0);
        chk("lb_wb1_data",   wb_o[1].reg_write_data, 32'hFFFF_FF80);
        chk("lb_wb1_addr",   32'(wb_o[1].reg_write_addr), 32'd7);
        chk("lb_wb0_data",   wb_o[0].reg_write_data, 32'h55);
        chk("lb_pf1_en",     32'(mem_reg_pf[1].en), 32'd1);

        // LBU at the same address, issued straight out of DONE
        ex_i[0] = mop(LBU, 5'd8, 32'h1003, '0);
        step();
        bubble();
        chk("lbu_req_valid", 32'(dcache_req_valid), 32'd1);
        step();
        dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0;
        chk("lbu_wb_data", wb_o[0].reg_write_data, 32'h0000_0080);

        // SH at 0x2002 with ready already high
        ex_i[0] = mop(SH, 5'd0, 32'h2002, 32'h0000_ABCD);
        step();
        bubble();
        chk("sh_valid", 32'(dcache_req_valid), 32'd1);
        chk("sh_we",    32'(dcache_req_we), 32'd1);
        chk("sh_wstrb", 32'(dcache_req_wstrb), 32'hC);
        chk("sh_wdata", dcache_req_wdata, 32'hABCD_ABCD);
        chk("sh_pause_1", 32'(pause_mem), 32'd1);
        step();
        chk("sh_pause_0", 32'(pause_mem), 32'd0);

        // pause held in DONE: no reload, no second request
        tb_pause = 1'b1;
        ex_i[0]  = mop(LW, 5'd4, 32'h6000, '0);
        step();
        step();
        chk("hold_req_valid", 32'(dcache_req_valid), 32'd0);
        chk("hold_pause_mem", 32'(pause_mem), 32'd0);
        bubble();
        tb_pause = 1'b0;
        step();

        // LW with slow handshake and slow response
        dcache_req_ready = 1'b0;
        ex_i[0] = mop(LW, 5'd6, 32'h3000, '0);
        step();
        bubble();
        pcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            dcache_req_ready  = (c == 3);
            dcache_resp_valid = (c == 5);
            dcache_resp_rdata = 32'hDEAD_BEEF;
            if (!pause_mem) break;
            pcnt++;
            if (dcache_req_valid) chk("lw_addr_stable", dcache_req_addr, 32'h3000);
            else chk("lw_wait_wb_zero", wb_o[0].reg_write_data, 32'd0);
            step();
        end
        dcache_req_ready  = 1'b0;
        dcache_resp_valid = 1'b0;
        chk("lw_pause_cycles", 32'(pcnt), 32'd5);
        chk("lw_wb_data",      wb_o[0].reg_write_data, 32'hDEAD_BEEF);
        chk("lw_pf_en",        32'(mem_reg_pf[0].en), 32'd1);
        chk("lw_pf_data",      mem_reg_pf[0].data, 32'hDEAD_BEEF);

        // flush in WAIT, new LW captured, stale response drained
        dcache_req_ready = 1'b1;
        ex_i[0] = mop(LW, 5'd2, 32'h4000, '0);
        step();
        bubble();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_drain_pause", 32'(pause_mem), 32'd0);
        chk("fl_drain_wb_en", 32'(wb_o[0].reg_write_en), 32'd0);
        ex_i[0] = mop(LW, 5'd9, 32'h5000, '0);
        step();
        bubble();
        chk("fl_drain_busy",  32'(pause_mem), 32'd1);
        chk("fl_drain_noreq", 32'(dcache_req_valid), 32'd0);
        step();
        dcache_resp_valid = 1'b1;
        dcache_resp_rdata = 32'h1111_1111;
        step();
        dcache_resp_valid = 1'b0;
        chk("fl_new_req",  32'(dcache_req_valid), 32'd1);
        chk("fl_new_addr", dcache_req_addr, 32'h5000);
        step();
        dcache_resp_valid = 1'b1;
        dcache_resp_rdata = 32'h2222_2222;
        step();
        dcache_resp_valid = 1'b0;
        chk("fl_new_pause", 32'(pause_mem), 32'd0);
        chk("fl_new_data",  wb_o[0].reg_write_data, 32'h2222_2222);
        chk("fl_new_rd",    32'(wb_o[0].reg_write_addr), 32'd9);

        // asynchronous reset in the middle of REQ
        dcache_req_ready = 1'b0;
        ex_i[0] = mop(LW, 5'd1, 32'h7000, '0);
        step();
        bubble();
        chk("ar_req_before", 32'(dcache_req_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_req_valid", 32'(dcache_req_valid), 32'd0);
        chk("ar_req_addr",  dcache_req_addr, 32'd0);
        chk("ar_pause",     32'(pause_mem), 32'd0);
        chk("ar_pf_en",     32'(mem_reg_pf[0].en), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("ar_after_idle", 32'(dcache_req_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
